// File: rtl/attn_softmax_r2b_sched.sv
// Scheduler between the B2R converter, the per-row softmax bank and the R2B
// tile converters. Issues softmax input strobes in a configurable row order,
// collects row outputs in ascending order into every channel of the current
// R2B tile, and generates local reset pulses plus slice-completion reporting.
//
// Handshakes: an issue happens when b2r_stream=1 and the pointed row is not
// busy. A collect happens when sm_out_valid[row] and r2b_ready[tile] are both
// high. Every output is registered, so each strobe appears one cycle after
// the cycle in which its condition was sampled.
module attn_softmax_r2b_sched #(
    parameter int NUM_ROWS    = 4,
    parameter int NUM_TILES   = 2,
    parameter int NUM_CH      = 2,
    parameter int SLICE_CNT_W = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cfg_reverse,
    input  logic [$clog2(NUM_ROWS):0]      cfg_num_rows,
    input  logic                           b2r_valid,
    input  logic                           b2r_stream,
    input  logic                           b2r_slice_done,
    output logic                           b2r_rst_n,
    output logic                           sm_en,
    output logic [NUM_ROWS-1:0]            sm_in_valid,
    input  logic [NUM_ROWS-1:0]            sm_busy,
    input  logic [NUM_ROWS-1:0]            sm_done,
    output logic [NUM_ROWS-1:0]            sm_rst_n,
    input  logic [NUM_ROWS-1:0]            sm_out_valid,
    output logic [NUM_ROWS-1:0]            sm_out_ack,
    output logic [NUM_CH*NUM_TILES-1:0]    r2b_in_valid,
    input  logic [NUM_TILES-1:0]           r2b_ready,
    input  logic [NUM_TILES-1:0]           r2b_slice_last,
    output logic [NUM_TILES-1:0]           r2b_rst_n,
    output logic [$clog2(NUM_ROWS)-1:0]    r2b_row_idx,
    output logic [$clog2(NUM_TILES):0]     r2b_tile_idx,
    output logic [SLICE_CNT_W-1:0]         slice_cnt,
    output logic                           slice_done,
    output logic                           busy
);
    localparam int RW = $clog2(NUM_ROWS);
    localparam int CW = RW + 1;
    localparam int TW = $clog2(NUM_TILES) + 1;
    localparam int VW = NUM_CH * NUM_TILES;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_DONE} state_e;

    state_e                 state_q, state_d;
    logic                   rev_q, rev_d;
    logic [CW-1:0]          n_q, n_d;
    logic [RW-1:0]          ptr_q, ptr_d;
    logic [RW-1:0]          row_q, row_d;
    logic [TW-1:0]          tile_q, tile_d;
    logic [SLICE_CNT_W-1:0] cnt_q, cnt_d;
    logic                   slice_done_q, slice_done_d;
    logic                   sm_en_q, sm_en_d;
    logic                   busy_q, busy_d;
    logic [NUM_ROWS-1:0]    in_valid_q, in_valid_d;
    logic [NUM_ROWS-1:0]    ack_q, ack_d;
    logic [VW-1:0]          r2b_v_q, r2b_v_d;
    logic                   b2r_rst_q;
    logic [NUM_ROWS-1:0]    sm_rst_q;
    logic [NUM_TILES-1:0]   r2b_rst_q;

    logic [CW-1:0] cfg_n;
    logic [RW-1:0] n_last;
    logic          busy_sel, valid_sel, ready_sel;
    logic          row_last, tile_last, issue, fire;

    // Next-state, pointer/index and strobe computation.
    always_comb begin
        state_d      = state_q;
        rev_d        = rev_q;
        n_d          = n_q;
        ptr_d        = ptr_q;
        row_d        = row_q;
        tile_d       = tile_q;
        cnt_d        = cnt_q;
        slice_done_d = 1'b0;
        sm_en_d      = sm_en_q;
        in_valid_d   = '0;
        ack_d        = '0;
        r2b_v_d      = '0;
        busy_sel     = 1'b0;
        valid_sel    = 1'b0;
        ready_sel    = 1'b0;

        // Out-of-range row counts fall back to the full bank.
        cfg_n  = (cfg_num_rows == '0 || cfg_num_rows > CW'(NUM_ROWS)) ? CW'(NUM_ROWS) : cfg_num_rows;
        n_last = RW'(n_q - CW'(1));

        for (int k = 0; k < NUM_ROWS; k++) begin
            if (ptr_q == RW'(k)) busy_sel  = sm_busy[k];
            if (row_q == RW'(k)) valid_sel = sm_out_valid[k];
        end
        for (int t = 0; t < NUM_TILES; t++) begin
            if (tile_q == TW'(t)) ready_sel = r2b_ready[t];
        end

        row_last  = (row_q == n_last);
        tile_last = (tile_q == TW'(NUM_TILES - 1));
        issue     = (state_q == ST_RUN) && b2r_stream && !busy_sel;
        fire      = ((state_q == ST_RUN) || (state_q == ST_FLUSH)) && valid_sel && ready_sel;

        case (state_q)
            ST_IDLE: begin
                rev_d  = cfg_reverse;
                n_d    = cfg_n;
                ptr_d  = cfg_reverse ? RW'(cfg_n - CW'(1)) : '0;
                row_d  = '0;
                tile_d = '0;
                if (b2r_valid) begin
                    state_d = ST_RUN;
                    sm_en_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (b2r_slice_done) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (fire && row_last && tile_last) state_d = ST_DONE;
            end
            ST_DONE: begin
                slice_done_d = 1'b1;
                cnt_d        = cnt_q + SLICE_CNT_W'(1);
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (issue) begin
            in_valid_d = NUM_ROWS'(1) << ptr_q;
            if (rev_q) ptr_d = (ptr_q == '0) ? n_last : ptr_q - RW'(1);
            else       ptr_d = (ptr_q == n_last) ? '0 : ptr_q + RW'(1);
        end

        if (fire) begin
            ack_d = NUM_ROWS'(1) << row_q;
            for (int c = 0; c < NUM_CH; c++) begin
                for (int t = 0; t < NUM_TILES; t++) begin
                    if (tile_q == TW'(t)) r2b_v_d[c*NUM_TILES+t] = 1'b1;
                end
            end
            if (row_last) begin
                row_d  = '0;
                tile_d = tile_last ? '0 : tile_q + TW'(1);
            end else begin
                row_d = row_q + RW'(1);
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rev_q        <= 1'b0;
            n_q          <= '0;
            ptr_q        <= '0;
            row_q        <= '0;
            tile_q       <= '0;
            cnt_q        <= '0;
            slice_done_q <= 1'b0;
            sm_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            in_valid_q   <= '0;
            ack_q        <= '0;
            r2b_v_q      <= '0;
            b2r_rst_q    <= 1'b0;
            sm_rst_q     <= '0;
            r2b_rst_q    <= '0;
        end else begin
            state_q      <= state_d;
            rev_q        <= rev_d;
            n_q          <= n_d;
            ptr_q        <= ptr_d;
            row_q        <= row_d;
            tile_q       <= tile_d;
            cnt_q        <= cnt_d;
            slice_done_q <= slice_done_d;
            sm_en_q      <= sm_en_d;
            busy_q       <= busy_d;
            in_valid_q   <= in_valid_d;
            ack_q        <= ack_d;
            r2b_v_q      <= r2b_v_d;
            b2r_rst_q    <= ~b2r_slice_done;
            sm_rst_q     <= ~sm_done;
            r2b_rst_q    <= ~r2b_slice_last;
        end
    end

    assign b2r_rst_n    = b2r_rst_q;
    assign sm_en        = sm_en_q;
    assign sm_in_valid  = in_valid_q;
    assign sm_rst_n     = sm_rst_q;
    assign sm_out_ack   = ack_q;
    assign r2b_in_valid = r2b_v_q;
    assign r2b_rst_n    = r2b_rst_q;
    assign r2b_row_idx  = row_q;
    assign r2b_tile_idx = tile_q;
    assign slice_cnt    = cnt_q;
    assign slice_done   = slice_done_q;
    assign busy         = busy_q;
endmodule
